// File: rtl/awb_pkg.sv
// Shared AWB definitions: FSM encoding, gain defaults and the statistics payload.
package awb_pkg;

    localparam int unsigned STAT_W        = 32;
    localparam int unsigned GAIN_W_DEF    = 12;
    localparam int unsigned GAIN_FRAC_DEF = 8;
    localparam int unsigned GAIN_UNITY    = 256;
    localparam int unsigned GAIN_MIN_DEF  = 64;
    localparam int unsigned GAIN_MAX_DEF  = 1023;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIV_R  = 2'd1,
        ST_DIV_B  = 2'd2,
        ST_UPDATE = 2'd3
    } awb_state_e;

    typedef struct packed {
        logic [STAT_W-1:0] r;
        logic [STAT_W-1:0] g;
        logic [STAT_W-1:0] b;
    } awb_sums_t;

endpackage

// File: rtl/awb_div_seq.sv
// Restoring unsigned divider, one quotient bit per cycle; the first bit is
// resolved on the start edge so done pulses NUM_W-1 edges after start.
module awb_div_seq #(
    parameter int unsigned NUM_W = 40,
    parameter int unsigned DEN_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [NUM_W-1:0] numerator,
    input  logic [DEN_W-1:0] denominator,
    output logic [NUM_W-1:0] quotient,
    output logic             done
);

    localparam int unsigned CNT_W = $clog2(NUM_W + 1);

    logic [DEN_W-1:0] rem_q;
    logic [DEN_W-1:0] den_q;
    logic [NUM_W-1:0] nq_q;
    logic [CNT_W-1:0] cnt_q;
    logic             active_q;

    logic [DEN_W-1:0] rem_in;
    logic [DEN_W-1:0] den_in;
    logic [NUM_W-1:0] nq_in;
    logic [DEN_W:0]   shifted;
    logic             fits;
    logic [DEN_W-1:0] rem_step;
    logic [NUM_W-1:0] nq_step;

    // One restoring step; a start replaces the working state with fresh operands.
    always_comb begin
        rem_in   = start ? '0 : rem_q;
        nq_in    = start ? numerator : nq_q;
        den_in   = start ? denominator : den_q;
        shifted  = {rem_in, nq_in[NUM_W-1]};
        fits     = (shifted >= {1'b0, den_in});
        rem_step = fits ? DEN_W'(shifted - {1'b0, den_in}) : shifted[DEN_W-1:0];
        nq_step  = {nq_in[NUM_W-2:0], fits};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q    <= '0;
            den_q    <= '0;
            nq_q     <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            done     <= 1'b0;
        end else if (start) begin
            rem_q    <= rem_step;
            nq_q     <= nq_step;
            den_q    <= denominator;
            cnt_q    <= CNT_W'(1);
            active_q <= 1'b1;
            done     <= 1'b0;
        end else if (active_q) begin
            rem_q <= rem_step;
            nq_q  <= nq_step;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(NUM_W - 1)) begin
                active_q <= 1'b0;
                done     <= 1'b1;
            end else begin
                done <= 1'b0;
            end
        end else begin
            done <= 1'b0;
        end
    end

    assign quotient = nq_q;

endmodule

// File: rtl/awb_gain_ctrl.sv
// Grey-world AWB gain controller: per-frame G/R and G/B ratios through a shared
// sequential divider, clamped and IIR-smoothed into registered gains.
module awb_gain_ctrl
    import awb_pkg::*;
#(
    parameter int unsigned GAIN_W       = GAIN_W_DEF,
    parameter int unsigned GAIN_FRAC    = GAIN_FRAC_DEF,
    parameter int unsigned GAIN_MIN     = GAIN_MIN_DEF,
    parameter int unsigned GAIN_MAX     = GAIN_MAX_DEF,
    parameter int unsigned SMOOTH_SHIFT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [STAT_W-1:0] r_sum_in,
    input  logic [STAT_W-1:0] g_sum_in,
    input  logic [STAT_W-1:0] b_sum_in,
    input  logic              frame_done_in,
    output logic [GAIN_W-1:0] r_gain,
    output logic [GAIN_W-1:0] g_gain,
    output logic [GAIN_W-1:0] b_gain,
    output logic              gain_valid,
    output logic              busy
);

    localparam int unsigned QUO_W  = STAT_W + GAIN_FRAC;
    localparam int unsigned DIFF_W = GAIN_W + 1;

    awb_state_e       state_q, state_nxt;
    awb_sums_t        sums_q, sums_nxt;
    logic             div_go_q, div_go_nxt;
    logic [GAIN_W-1:0] r_tgt_q, r_tgt_nxt;
    logic [GAIN_W-1:0] b_tgt_q, b_tgt_nxt;
    logic [GAIN_W-1:0] r_gain_nxt, b_gain_nxt;
    logic             valid_nxt;

    logic             div_start_c;
    logic             div_done;
    logic [QUO_W-1:0] div_quo;
    logic [QUO_W-1:0] num_c;
    logic             sel_b_c;
    logic [STAT_W-1:0] den_raw_c;
    logic [STAT_W-1:0] den_c;
    logic             chan_zero_c;
    logic [GAIN_W-1:0] tgt_c;

    // Clamp on the full-width quotient so large ratios cannot wrap into range.
    function automatic logic [GAIN_W-1:0] clamp_gain(input logic [QUO_W-1:0] q);
        if (q < QUO_W'(GAIN_MIN)) begin
            return GAIN_W'(GAIN_MIN);
        end else if (q > QUO_W'(GAIN_MAX)) begin
            return GAIN_W'(GAIN_MAX);
        end else begin
            return GAIN_W'(q);
        end
    endfunction

    // Step toward target by diff>>>SHIFT, never less than one LSB, so it lands exactly.
    function automatic logic [GAIN_W-1:0] smooth_gain(input logic [GAIN_W-1:0] old_g,
                                                      input logic [GAIN_W-1:0] tgt_g);
        logic signed [DIFF_W-1:0] diff;
        logic signed [DIFF_W-1:0] step;
        diff = $signed({1'b0, tgt_g}) - $signed({1'b0, old_g});
        step = diff >>> SMOOTH_SHIFT;
        if (diff != '0 && step == '0) begin
            step = diff[DIFF_W-1] ? '1 : DIFF_W'(1);
        end
        return GAIN_W'($signed({1'b0, old_g}) + step);
    endfunction

    // Divider operands: first divide uses R, the chained restart uses B.
    always_comb begin
        sel_b_c     = (state_q == ST_DIV_R) && !div_go_q;
        num_c       = QUO_W'(sums_q.g) << GAIN_FRAC;
        den_raw_c   = sel_b_c ? sums_q.b : sums_q.r;
        // A zero denominator is replaced by 1 only to keep timing; its quotient is discarded.
        den_c       = (den_raw_c == '0) ? STAT_W'(1) : den_raw_c;
        div_start_c = enable && (div_go_q || (sel_b_c && div_done));
        chan_zero_c = (state_q == ST_DIV_B) ? (sums_q.b == '0) : (sums_q.r == '0);
        tgt_c       = chan_zero_c ? GAIN_W'(GAIN_MAX) : clamp_gain(div_quo);
    end

    awb_div_seq #(
        .NUM_W (QUO_W),
        .DEN_W (STAT_W)
    ) u_div (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (div_start_c),
        .numerator   (num_c),
        .denominator (den_c),
        .quotient    (div_quo),
        .done        (div_done)
    );

    always_comb begin
        state_nxt  = state_q;
        sums_nxt   = sums_q;
        div_go_nxt = 1'b0;
        r_tgt_nxt  = r_tgt_q;
        b_tgt_nxt  = b_tgt_q;
        r_gain_nxt = r_gain;
        b_gain_nxt = b_gain;
        valid_nxt  = 1'b0;

        if (!enable) begin
            state_nxt  = ST_IDLE;
            r_gain_nxt = GAIN_W'(GAIN_UNITY);
            b_gain_nxt = GAIN_W'(GAIN_UNITY);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (frame_done_in) begin
                        state_nxt  = ST_DIV_R;
                        sums_nxt.r = r_sum_in;
                        sums_nxt.g = g_sum_in;
                        sums_nxt.b = b_sum_in;
                        div_go_nxt = 1'b1;
                    end
                end
                ST_DIV_R: begin
                    // div_go_q masks a done left over from an aborted divide.
                    if (div_done && !div_go_q) begin
                        r_tgt_nxt = tgt_c;
                        state_nxt = ST_DIV_B;
                    end
                end
                ST_DIV_B: begin
                    if (div_done) begin
                        b_tgt_nxt = tgt_c;
                        state_nxt = ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    state_nxt = ST_IDLE;
                    if (sums_q.g != '0) begin
                        r_gain_nxt = smooth_gain(r_gain, r_tgt_q);
                        b_gain_nxt = smooth_gain(b_gain, b_tgt_q);
                        valid_nxt  = 1'b1;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            sums_q     <= '0;
            div_go_q   <= 1'b0;
            r_tgt_q    <= GAIN_W'(GAIN_UNITY);
            b_tgt_q    <= GAIN_W'(GAIN_UNITY);
            r_gain     <= GAIN_W'(GAIN_UNITY);
            b_gain     <= GAIN_W'(GAIN_UNITY);
            gain_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            sums_q     <= sums_nxt;
            div_go_q   <= div_go_nxt;
            r_tgt_q    <= r_tgt_nxt;
            b_tgt_q    <= b_tgt_nxt;
            r_gain     <= r_gain_nxt;
            b_gain     <= b_gain_nxt;
            gain_valid <= valid_nxt;
            busy       <= (state_nxt != ST_IDLE);
        end
    end

    assign g_gain = GAIN_W'(GAIN_UNITY);

endmodule
